// File: rtl/ewrapper_link_rxi_decode.sv
// LVDS link receive decoder: rebuilds 64-bit beats from the deserializer word and emits registered emesh transactions.
// Optional saturating framing-error counter on rxi_err_cnt when RXI_ERR_CNT_EN is defined.
module ewrapper_link_rxi_decode #(
  parameter int ERR_CNT_W = 8
) (
  input  logic        rxi_lclk,
  input  logic        reset_n,
  input  logic [71:0] rx_out,
  output logic        rxi_emesh_access,
  output logic        rxi_emesh_write,
  output logic [1:0]  rxi_emesh_datamode,
  output logic [3:0]  rxi_emesh_ctrlmode,
  output logic [31:0] rxi_emesh_dstaddr,
  output logic [31:0] rxi_emesh_srcaddr,
  output logic [31:0] rxi_emesh_data,
  output logic        rxi_frame_err
`ifdef RXI_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0] rxi_err_cnt
`endif
);

  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  if (ERR_CNT_W < 1) begin : g_bad_w
    $error("ERR_CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  logic [NUM_LANES*VEC_W-1:0] beat;
  logic [7:0] frame;
  logic       is_idle, is_hdr, is_data, err_nxt;

  // Each channel carries one bit of every byte lane: bit k of channel c is beat bit 8k+c.
  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    for (genvar k = 0; k < VEC_W; k++) begin : g_bit
      assign beat[NUM_LANES*k+c] = rx_out[VEC_W*c+k];
    end
  end

  assign frame   = rx_out[71:64];
  assign is_idle = (frame == 8'h00);
  assign is_hdr  = (frame == 8'h3F);
  assign is_data = (frame == 8'hFF);

  state_t      state;
  logic        h_write, h_inc0, dbl;
  logic [1:0]  h_datamode;
  logic [3:0]  h_ctrlmode;
  logic [31:0] h_dstaddr;

  always_comb begin
    err_nxt = 1'b0;
    case (state)
      IDLE:    err_nxt = !is_idle && !is_hdr;
      HDR:     err_nxt = !is_data;
      DATA:    err_nxt = (is_data && !dbl) || (!is_data && !is_hdr && !is_idle);
      default: err_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge rxi_lclk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      h_write            <= 1'b0;
      h_inc0             <= 1'b0;
      h_datamode         <= 2'b0;
      h_ctrlmode         <= 4'b0;
      h_dstaddr          <= 32'b0;
      dbl                <= 1'b0;
      rxi_emesh_access   <= 1'b0;
      rxi_emesh_write    <= 1'b0;
      rxi_emesh_datamode <= 2'b0;
      rxi_emesh_ctrlmode <= 4'b0;
      rxi_emesh_dstaddr  <= 32'b0;
      rxi_emesh_srcaddr  <= 32'b0;
      rxi_emesh_data     <= 32'b0;
      rxi_frame_err      <= 1'b0;
    end else begin
      rxi_emesh_access <= 1'b0;
      rxi_frame_err    <= err_nxt;
      // Any 3F frame re-latches the header; the header's own access bit is ignored.
      if (is_hdr) begin
        h_write    <= beat[1];
        h_datamode <= beat[3:2];
        h_dstaddr  <= beat[35:4];
        h_ctrlmode <= beat[39:36];
        h_inc0     <= beat[42];
      end
      case (state)
        IDLE: if (is_hdr) state <= HDR;
        HDR: begin
          if (is_data) begin
            rxi_emesh_access   <= 1'b1;
            rxi_emesh_write    <= h_write;
            rxi_emesh_datamode <= h_datamode;
            rxi_emesh_ctrlmode <= h_ctrlmode;
            rxi_emesh_dstaddr  <= h_dstaddr;
            rxi_emesh_srcaddr  <= beat[31:0];
            rxi_emesh_data     <= beat[63:32];
            dbl                <= h_write && (h_datamode == 2'b11);
            state              <= DATA;
          end else if (!is_hdr) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (is_data && dbl) begin
            rxi_emesh_access  <= 1'b1;
            rxi_emesh_dstaddr <= rxi_emesh_dstaddr + (h_inc0 ? 32'd0 : 32'd8);
            rxi_emesh_srcaddr <= beat[31:0];
            rxi_emesh_data    <= beat[63:32];
          end else if (is_hdr) begin
            state <= HDR;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RXI_ERR_CNT_EN
  always_ff @(posedge rxi_lclk or negedge reset_n) begin
    if (!reset_n)
      rxi_err_cnt <= '0;
    else if (err_nxt && (rxi_err_cnt != {ERR_CNT_W{1'b1}}))
      rxi_err_cnt <= rxi_err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ewrapper_link_rxi_decode.sv
// Scoreboard bench for ewrapper_link_rxi_decode: directed link frames, expected transactions and
// frame errors queued with their due cycle, checked by an independent monitor.
module tb_ewrapper_link_rxi_decode;
  typedef struct packed {
    logic        write;
    logic [1:0]  dm;
    logic [3:0]  ctrl;
    logic [31:0] dst;
    logic [31:0] src;
    logic [31:0] data;
  } tr_t;

  logic        rxi_lclk = 1'b0;
  logic        reset_n;
  logic [71:0] rx_out;
  logic        rxi_emesh_access, rxi_emesh_write, rxi_frame_err;
  logic [1:0]  rxi_emesh_datamode;
  logic [3:0]  rxi_emesh_ctrlmode;
  logic [31:0] rxi_emesh_dstaddr, rxi_emesh_srcaddr, rxi_emesh_data;
`ifdef RXI_ERR_CNT_EN
  logic [7:0]  rxi_err_cnt;
`endif

  ewrapper_link_rxi_decode #(.ERR_CNT_W(8)) dut (
    .rxi_lclk(rxi_lclk), .reset_n(reset_n), .rx_out(rx_out),
    .rxi_emesh_access(rxi_emesh_access), .rxi_emesh_write(rxi_emesh_write),
    .rxi_emesh_datamode(rxi_emesh_datamode), .rxi_emesh_ctrlmode(rxi_emesh_ctrlmode),
    .rxi_emesh_dstaddr(rxi_emesh_dstaddr), .rxi_emesh_srcaddr(rxi_emesh_srcaddr),
    .rxi_emesh_data(rxi_emesh_data), .rxi_frame_err(rxi_frame_err)
`ifdef RXI_ERR_CNT_EN
    , .rxi_err_cnt(rxi_err_cnt)
`endif
  );

  always #5 rxi_lclk = ~rxi_lclk;

  int cyc = 0;
  always @(posedge rxi_lclk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  tr_t exp_tr[$];
  int  exp_cy[$];
  int  exp_err[$];

  function automatic logic [71:0] pk(input logic [7:0] f, input logic [63:0] b);
    logic [71:0] r;
    r[71:64] = f;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++)
        r[8*c+k] = b[8*k+c];
    return r;
  endfunction

  function automatic logic [63:0] hb(input logic acc, input logic wr, input logic [1:0] dm,
                                     input logic [3:0] ctrl, input logic [31:0] dst,
                                     input logic [7:0] tb0);
    return {16'hABCD, tb0, ctrl, dst, dm, wr, acc};
  endfunction

  function automatic tr_t mk(input logic wr, input logic [1:0] dm, input logic [3:0] ctrl,
                             input logic [31:0] dst, input logic [31:0] src, input logic [31:0] d);
    return {wr, dm, ctrl, dst, src, d};
  endfunction

  task automatic word(input logic [7:0] f, input logic [63:0] b, input bit acc, input tr_t t,
                      input bit err);
    @(negedge rxi_lclk);
    rx_out = pk(f, b);
    if (acc) begin exp_tr.push_back(t); exp_cy.push_back(cyc + 1); end
    if (err) exp_err.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) word(8'h00, 64'h0, 0, '0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " access"}, {31'b0, rxi_emesh_access}, 32'h0);
    check({tag, " frame_err"}, {31'b0, rxi_frame_err}, 32'h0);
    check({tag, " write/dm/ctrl"}, {25'b0, rxi_emesh_write, rxi_emesh_datamode, rxi_emesh_ctrlmode}, 32'h0);
    check({tag, " dstaddr"}, rxi_emesh_dstaddr, 32'h0);
    check({tag, " srcaddr"}, rxi_emesh_srcaddr, 32'h0);
    check({tag, " data"}, rxi_emesh_data, 32'h0);
  endtask

  // Monitor: every access / frame_err pulse must match the head of its queue, on the due cycle.
  always @(negedge rxi_lclk) begin
    tr_t a, e;
    int ec;
    if (rxi_emesh_access) begin
      total++;
      a = {rxi_emesh_write, rxi_emesh_datamode, rxi_emesh_ctrlmode,
           rxi_emesh_dstaddr, rxi_emesh_srcaddr, rxi_emesh_data};
      if (exp_tr.size() == 0) begin
        bad++;
        $display("FAIL spurious access cyc=%0d got=%h", cyc, a);
      end else begin
        e = exp_tr.pop_front();
        ec = exp_cy.pop_front();
        if (a !== e || cyc != ec) begin
          bad++;
          $display("FAIL tran cyc got=%0d want=%0d fields got=%h want=%h", cyc, ec, a, e);
        end
      end
    end
    if (rxi_frame_err) begin
      total++;
      if (exp_err.size() == 0) begin
        bad++;
        $display("FAIL spurious frame_err cyc=%0d", cyc);
      end else begin
        ec = exp_err.pop_front();
        if (cyc != ec) begin
          bad++;
          $display("FAIL frame_err cyc got=%0d want=%0d", cyc, ec);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    rx_out  = 72'h0;
    repeat (2) @(negedge rxi_lclk);
    #1;
    check_zero_outputs("reset");
`ifdef RXI_ERR_CNT_EN
    check("reset err_cnt", {24'b0, rxi_err_cnt}, 32'h0);
`endif
    @(negedge rxi_lclk);
    reset_n = 1'b1;
    idle(2);

    // Single write
    word(8'h3F, hb(1, 1, 2'd2, 4'h0, 32'h80801000, 8'h00), 0, '0, 0);
    word(8'hFF, {32'h22222222, 32'h11111111}, 1,
         mk(1, 2'd2, 4'h0, 32'h80801000, 32'h11111111, 32'h22222222), 0);
    idle(3);
    // Output hold while access is low
    check("hold dstaddr", rxi_emesh_dstaddr, 32'h80801000);
    check("hold data", rxi_emesh_data, 32'h22222222);

    // Burst, increment by 8
    word(8'h3F, hb(1, 1, 2'd3, 4'h5, 32'h00000FF8, 8'h00), 0, '0, 0);
    word(8'hFF, {32'hD0000001, 32'hA0000001}, 1, mk(1, 2'd3, 4'h5, 32'h00000FF8, 32'hA0000001, 32'hD0000001), 0);
    word(8'hFF, {32'hD0000002, 32'hA0000002}, 1, mk(1, 2'd3, 4'h5, 32'h00001000, 32'hA0000002, 32'hD0000002), 0);
    word(8'hFF, {32'hD0000003, 32'hA0000003}, 1, mk(1, 2'd3, 4'h5, 32'h00001008, 32'hA0000003, 32'hD0000003), 0);
    idle(2);

    // Burst, inc0; header access bit cleared, emission still driven by frame code
    word(8'h3F, hb(0, 1, 2'd3, 4'h5, 32'h00000FF8, 8'h04), 0, '0, 0);
    word(8'hFF, {32'hE0000001, 32'hB0000001}, 1, mk(1, 2'd3, 4'h5, 32'h00000FF8, 32'hB0000001, 32'hE0000001), 0);
    word(8'hFF, {32'hE0000002, 32'hB0000002}, 1, mk(1, 2'd3, 4'h5, 32'h00000FF8, 32'hB0000002, 32'hE0000002), 0);
    idle(2);

    // Wrap, then a header straight out of DATA
    word(8'h3F, hb(1, 1, 2'd3, 4'h9, 32'hFFFFFFF8, 8'h00), 0, '0, 0);
    word(8'hFF, {32'h0000CAFE, 32'h0000BEEF}, 1, mk(1, 2'd3, 4'h9, 32'hFFFFFFF8, 32'h0000BEEF, 32'h0000CAFE), 0);
    word(8'hFF, {32'h1234CAFE, 32'h1234BEEF}, 1, mk(1, 2'd3, 4'h9, 32'h00000000, 32'h1234BEEF, 32'h1234CAFE), 0);
    word(8'h3F, hb(1, 0, 2'd1, 4'h3, 32'h40000004, 8'h00), 0, '0, 0);
    word(8'hFF, {32'h55555555, 32'h66666666}, 1, mk(0, 2'd1, 4'h3, 32'h40000004, 32'h66666666, 32'h55555555), 0);
    idle(2);

    // Framing errors
    word(8'hFF, 64'h0, 0, '0, 1);
    idle(1);
    word(8'h3F, hb(1, 1, 2'd2, 4'h0, 32'h00002000, 8'h00), 0, '0, 0);
    word(8'h5A, 64'h0, 0, '0, 1);
    idle(1);
    word(8'h3F, hb(1, 1, 2'd2, 4'h1, 32'h00003000, 8'h00), 0, '0, 0);
    word(8'hFF, {32'h77777777, 32'h88888888}, 1, mk(1, 2'd2, 4'h1, 32'h00003000, 32'h88888888, 32'h77777777), 0);
    word(8'hFF, 64'h0, 0, '0, 1);
    idle(3);
`ifdef RXI_ERR_CNT_EN
    check("err_cnt after 3", {24'b0, rxi_err_cnt}, 32'd3);
`endif
    for (int i = 0; i < 300; i++) word(8'hFF, 64'h0, 0, '0, 1);
    idle(3);
`ifdef RXI_ERR_CNT_EN
    check("err_cnt saturate", {24'b0, rxi_err_cnt}, 32'd255);
`endif

    // Reset mid-transaction
    word(8'h3F, hb(1, 1, 2'd2, 4'h2, 32'h00005000, 8'h00), 0, '0, 0);
    @(negedge rxi_lclk);
    reset_n = 1'b0;
    rx_out  = 72'h0;
    #1;
    check_zero_outputs("midreset");
`ifdef RXI_ERR_CNT_EN
    check("midreset err_cnt", {24'b0, rxi_err_cnt}, 32'h0);
`endif
    @(negedge rxi_lclk);
    reset_n = 1'b1;
    rx_out  = pk(8'hFF, {32'h99999999, 32'hAAAAAAAA});
    exp_err.push_back(cyc + 1);
    idle(3);
`ifdef RXI_ERR_CNT_EN
    check("err_cnt after reset", {24'b0, rxi_err_cnt}, 32'd1);
`endif

    idle(4);
    check("pending transactions", exp_tr.size(), 32'd0);
    check("pending frame errors", exp_err.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ewrapper_link_rxi_decode.md
Name: ewrapper_link_rxi_decode

Overview:
- Link-layer receive decoder on the far side of the LVDS link.
- Consumes the 72-bit per-cycle word produced by the LVDS deserializer: 8 frame bits, then channel7..channel0, each 8 bits.
- Recovers 64-bit beats, decodes header/data cycles and double-write bursts, and presents one registered emesh transaction per data beat.
- No backpressure: the link cannot be stalled, so every decoded beat is emitted.

Parameters:
- ERR_CNT_W, 8, width of the saturating framing-error counter (used only with the optional feature).

Ports:
- rxi_lclk  input  1  receiver link clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_out  input  72  deserializer word. [71:64] is the frame byte; [63:0] is channel7..channel0, 8 bits each.
- rxi_emesh_access  output  1  one-cycle pulse marking a valid transaction.
- rxi_emesh_write  output  1  write flag.
- rxi_emesh_datamode  output  2  datamode.
- rxi_emesh_ctrlmode  output  4  ctrlmode.
- rxi_emesh_dstaddr  output  32  destination address.
- rxi_emesh_srcaddr  output  32  source address / upper data.
- rxi_emesh_data  output  32  data.
- rxi_frame_err  output  1  one-cycle pulse on a framing violation.
- rxi_err_cnt  output  ERR_CNT_W  saturating error count. Present only with RXI_ERR_CNT_EN.

Behaviour:
- Beat reconstruction (combinational):
  - beat[8*k+c] = rx_out[8*c+k] for c = channel 0..7 and k = bit 0..7.
  - frame = rx_out[71:64].
- Frame codes:
  - 8'h00 = idle.
  - 8'h3F = header.
  - 8'hFF = data.
  - Any other value is illegal.
- Header fields:
  - access = beat[0], write = beat[1], datamode = beat[3:2].
  - dstaddr = beat[35:4], ctrlmode = beat[39:36].
  - tran_byte0 = beat[47:40]; inc0 = beat[42].
  - beat[63:48] is ignored.
- Data fields: srcaddr = beat[31:0], data = beat[63:32].
- FSM states: IDLE, HDR, DATA. Reset state is IDLE.
- IDLE:
  - 00: stay in IDLE.
  - 3F: latch the header and go to HDR.
  - FF or illegal: frame_err pulse, stay in IDLE.
- HDR:
  - FF: emit transaction (latched header + this beat), go to DATA. Record dbl = write & datamode==2'b11.
  - 3F: frame_err, re-latch header, stay in HDR.
  - 00 or illegal: frame_err, go to IDLE.
- DATA:
  - FF with dbl=1 (burst beat): increment dstaddr by 8, or by 0 if inc0=1, with 32-bit wrap (0xFFFFFFF8+8 = 0x00000000). Emit with the new srcaddr/data, stay in DATA.
  - FF with dbl=0: frame_err, no emit, go to IDLE.
  - 3F: latch new header, go to HDR.
  - 00: go to IDLE.
  - Illegal: frame_err, go to IDLE.
- Latency: outputs are registered one rxi_lclk after the data (FF) word is sampled. Back-to-back bursts give access high on consecutive cycles.
- Output hold: when access=0, the other rxi_emesh_* outputs hold their last value.
- The latched access bit is not gated. Only the frame code decides emission.
- Reset values: access=0, frame_err=0, err_cnt=0, write=0, datamode=0, ctrlmode=0, dstaddr=0, srcaddr=0, data=0, state=IDLE.
- Reset asserted mid-transaction:
  - Outputs clear immediately (asynchronously).
  - A pending header is discarded.
  - After release, the next cycle decodes from IDLE.

Optional Feature:
- Macro: RXI_ERR_CNT_EN.
- Defined:
  - rxi_err_cnt port exists.
  - It increments on every frame_err pulse and saturates at all-ones.
  - It resets to 0.
- Undefined:
  - The port and counter are absent.
  - rxi_frame_err pulse behaviour is unchanged.

Test Plan:
- Single write:
  - Stimulus: 3F header (write=1, datamode=2, ctrlmode=0, dstaddr=0x80801000), then FF (srcaddr=0x11111111, data=0x22222222), then 00.
  - Response: one access pulse 1 cycle after FF with those exact fields; frame_err never asserts.
- Burst inc8:
  - Stimulus: double-write header dstaddr=0x00000FF8, inc0=0, then FF,FF,FF.
  - Response: three consecutive pulses with dstaddr 0x00000FF8, 0x00001000, 0x00001008.
- Burst inc0:
  - Stimulus: same header with inc0=1, then FF,FF.
  - Response: both pulses have dstaddr 0x00000FF8.
- Wrap:
  - Stimulus: double-write header dstaddr=0xFFFFFFF8, then FF,FF.
  - Response: second pulse dstaddr=0x00000000.
- Framing errors:
  - Stimulus: FF in IDLE; 3F then 5A; single write (datamode=2) then an extra FF.
  - Response: three frame_err pulses, no spurious access. With RXI_ERR_CNT_EN, err_cnt=3; after 300 errors, err_cnt=255.
- Reset mid-operation:
  - Stimulus: reset_n low for 1 cycle after a 3F header, then FF.
  - Response: no access pulse; frame_err pulses once; outputs read 0 during reset.
